// File: rtl/beh_alu_pkg.sv
// beh_alu_pkg: opcodes, widths and reset value shared by the ALU slice.
package beh_alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;
    localparam int DW = 8;
    localparam int RW = 9;
    localparam logic [RW-1:0] RES_RST = 9'h000;
endpackage

// File: rtl/beh_alu_if.sv
// beh_alu_if: operand/opcode/result bundle for beh_alu; flag signals exist only with BEH_ALU_FLAGS_EN.
interface beh_alu_if;
    import beh_alu_pkg::*;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [1:0]    ALUOp;
    logic [RW-1:0] Out;
`ifdef BEH_ALU_FLAGS_EN
    logic          zero;
    logic          ovf;
`endif
    modport master (
        output A, B, ALUOp,
        input  Out
`ifdef BEH_ALU_FLAGS_EN
        , input zero, ovf
`endif
    );
    modport slave (
        input  A, B, ALUOp,
        output Out
`ifdef BEH_ALU_FLAGS_EN
        , output zero, ovf
`endif
    );
endinterface

// File: rtl/beh_alu_core.sv
// beh_alu_core: combinational 8-bit add/sub/and/or with 9-bit result.
// Zero/overflow flag outputs exist only with BEH_ALU_FLAGS_EN.
module beh_alu_core
    import beh_alu_pkg::*;
(
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [1:0]    ALUOp,
    output logic [RW-1:0] res
`ifdef BEH_ALU_FLAGS_EN
    ,
    output logic          zero_c,
    output logic          ovf_c
`endif
);
    // bit 8 of the 9-bit sub is the borrow, set exactly when A < B
    always_comb begin
        res = ALUOp == OP_ADD ? {1'b0, A} + {1'b0, B} :
              ALUOp == OP_SUB ? {1'b0, A} - {1'b0, B} :
              ALUOp == OP_AND ? {1'b0, A & B} :
                                {1'b0, A | B};
    end
`ifdef BEH_ALU_FLAGS_EN
    always_comb begin
        zero_c = res[DW-1:0] == '0;
        ovf_c  = ALUOp == OP_ADD ? (A[DW-1] == B[DW-1]) && (res[DW-1] != A[DW-1]) :
                 ALUOp == OP_SUB ? (A[DW-1] != B[DW-1]) && (res[DW-1] != A[DW-1]) :
                                   1'b0;
    end
`endif
endmodule

// File: rtl/beh_alu.sv
// beh_alu: 8-bit four-function ALU with registered 9-bit result (bit 8 = carry/borrow).
// Optional registered zero/ovf flags with BEH_ALU_FLAGS_EN.
module beh_alu
    import beh_alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [1:0]    ALUOp,
    output logic [RW-1:0] Out
`ifdef BEH_ALU_FLAGS_EN
    ,
    output logic          zero,
    output logic          ovf
`endif
);
    logic [RW-1:0] w_res;
    logic [RW-1:0] r_out;
`ifdef BEH_ALU_FLAGS_EN
    logic w_zero;
    logic w_ovf;
    logic r_zero;
    logic r_ovf;
`endif
    beh_alu_core u_core (
        .A     (A),
        .B     (B),
        .ALUOp (ALUOp),
        .res   (w_res)
`ifdef BEH_ALU_FLAGS_EN
        ,
        .zero_c(w_zero),
        .ovf_c (w_ovf)
`endif
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= RES_RST;
        end else begin
            r_out <= w_res;
        end
    end
    assign Out = r_out;
`ifdef BEH_ALU_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b1;
            r_ovf  <= 1'b0;
        end else begin
            r_zero <= w_zero;
            r_ovf  <= w_ovf;
        end
    end
    assign zero = r_zero;
    assign ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_beh_alu.sv
// tb_beh_alu: directed and swept checks of beh_alu; flag checks active with BEH_ALU_FLAGS_EN.
module tb_beh_alu;
    import beh_alu_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    beh_alu_if bus ();
    always #5 clk = ~clk;
    beh_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (bus.A),
        .B     (bus.B),
        .ALUOp (bus.ALUOp),
        .Out   (bus.Out)
`ifdef BEH_ALU_FLAGS_EN
        ,
        .zero  (bus.zero),
        .ovf   (bus.ovf)
`endif
    );
    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk_f(input string tag, input logic z, input logic v);
`ifdef BEH_ALU_FLAGS_EN
        chk({tag, ".zero"}, {8'h0, bus.zero}, {8'h0, z});
        chk({tag, ".ovf"}, {8'h0, bus.ovf}, {8'h0, v});
`else
        if (z === 1'bx && v === 1'bx) $display("unused %s", tag);
`endif
    endtask
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bus.A = a;
        bus.B = b;
        bus.ALUOp = op;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [8:0] ref_out(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int s;
        case (op)
            2'd0:    s = int'(a) + int'(b);
            2'd1:    s = int'(a) - int'(b);
            2'd2:    s = int'(a & b);
            default: s = int'(a | b);
        endcase
        return s[8:0];
    endfunction
    function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int r;
        r = op == 2'd0 ? int'($signed(a)) + int'($signed(b)) :
            op == 2'd1 ? int'($signed(a)) - int'($signed(b)) : 0;
        return r > 127 || r < -128;
    endfunction
    initial begin
        logic [8:0] e;
        rst_n = 1'b0;
        bus.A = 8'h00;
        bus.B = 8'h00;
        bus.ALUOp = OP_ADD;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", bus.Out, 9'h000);
        chk_f("reset", 1'b1, 1'b0);
        rst_n = 1'b1;
        step(8'h05, 8'h03, OP_ADD);
        chk("add_5_3", bus.Out, 9'h008);
        chk_f("add_5_3", 1'b0, 1'b0);
        step(8'hFF, 8'h01, OP_ADD);
        chk("add_carry", bus.Out, 9'h100);
        chk_f("add_carry", 1'b1, 1'b0);
        step(8'h7F, 8'h01, OP_ADD);
        chk("add_ovf", bus.Out, 9'h080);
        chk_f("add_ovf", 1'b0, 1'b1);
        step(8'hFF, 8'hFF, OP_ADD);
        chk("add_max", bus.Out, 9'h1FE);
        step(8'h00, 8'h01, OP_SUB);
        chk("sub_borrow", bus.Out, 9'h1FF);
        chk_f("sub_borrow", 1'b0, 1'b0);
        step(8'h80, 8'h01, OP_SUB);
        chk("sub_ovf", bus.Out, 9'h07F);
        chk_f("sub_ovf", 1'b0, 1'b1);
        step(8'h5A, 8'h5A, OP_SUB);
        chk("sub_eq", bus.Out, 9'h000);
        chk_f("sub_eq", 1'b1, 1'b0);
        step(8'hF0, 8'h3C, OP_AND);
        chk("and", bus.Out, 9'h030);
        chk_f("and", 1'b0, 1'b0);
        step(8'hF0, 8'h3C, OP_OR);
        chk("or", bus.Out, 9'h0FC);
        step(8'hFF, 8'hFF, OP_OR);
        chk("or_ff", bus.Out, 9'h0FF);
        chk_f("or_ff", 1'b0, 1'b0);
        step(8'h00, 8'h01, OP_SUB);
        chk("pre_async", bus.Out, 9'h1FF);
        #2 rst_n = 1'b0;
        #1 chk("async_now", bus.Out, 9'h000);
        chk_f("async_now", 1'b1, 1'b0);
        @(posedge clk);
        #1 chk("async_hold", bus.Out, 9'h000);
        #1 rst_n = 1'b1;
        bus.A = 8'h05;
        bus.B = 8'h03;
        bus.ALUOp = OP_ADD;
        #1 chk("post_release", bus.Out, 9'h000);
        @(posedge clk);
        #1 chk("first_load", bus.Out, 9'h008);
        for (int a = 0; a < 256; a += 17) begin
            for (int b = 0; b < 256; b += 17) begin
                for (int op = 0; op < 4; op++) begin
                    step(8'(a), 8'(b), 2'(op));
                    e = ref_out(8'(a), 8'(b), 2'(op));
                    chk($sformatf("sweep_%02h_%02h_%0d", a, b, op), bus.Out, e);
                    chk_f("sweep", e[7:0] == 8'h00, ref_ovf(8'(a), 8'(b), 2'(op)));
                end
            end
        end
        for (int i = 0; i < 600; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [1:0] ro;
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            ro = 2'($urandom_range(3));
            step(ra, rb, ro);
            e = ref_out(ra, rb, ro);
            chk($sformatf("rand_%02h_%02h_%0d", ra, rb, ro), bus.Out, e);
            chk_f("rand", e[7:0] == 8'h00, ref_ovf(ra, rb, ro));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
